// File: rtl/count_seq_monitor.sv
// Monitors a free-running count and checks that each sample advances by +1 (mod 2^WIDTH).
// Reports wraps, compare matches and sequence errors, and keeps wrap and saturating error counts.
module count_seq_monitor #(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8,
   parameter int ERR_W  = 4,
   parameter int LOCK_N = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_clear,
   input  logic [WIDTH-1:0]  i_cnt,
   input  logic [WIDTH-1:0]  i_cmp_val,
   output logic              o_wrap_pulse,
   output logic              o_match_pulse,
   output logic              o_seq_err,
   output logic              o_err_sticky,
   output logic              o_locked,
   output logic [WRAP_W-1:0] o_wrap_cnt,
   output logic [ERR_W-1:0]  o_err_cnt,
   output logic [1:0]        o_state
);

   localparam int GOOD_W = $clog2(LOCK_N + 1);

   typedef enum logic [1:0] {
      ST_UNSYNC  = 2'b00,
      ST_RESYNC  = 2'b01,
      ST_TRACK   = 2'b10,
      ST_ILLEGAL = 2'b11
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_prev;
   logic [GOOD_W-1:0]  r_good;

   logic [WIDTH-1:0]   w_prev_inc;
   logic [GOOD_W-1:0]  w_good_inc;
   logic               w_inc;
   logic               w_hold;
   logic               w_checking;
   logic               w_bad_evt;
   logic               w_wrap_evt;
   logic               w_lock_hit;
   logic               w_err_sat;

   assign w_prev_inc = r_prev + {{(WIDTH-1){1'b0}}, 1'b1};
   assign w_good_inc = r_good + {{(GOOD_W-1){1'b0}}, 1'b1};
   assign w_inc      = (i_cnt == w_prev_inc);
   assign w_hold     = (i_cnt == r_prev);
   // Step checks only apply once a previous sample has been captured.
   assign w_checking = i_en && ((r_state == ST_RESYNC) || (r_state == ST_TRACK));
   assign w_bad_evt  = w_checking && !w_inc && !w_hold;
   assign w_wrap_evt = w_checking && w_inc && (r_prev == {WIDTH{1'b1}});
   assign w_lock_hit = (w_good_inc == GOOD_W'(LOCK_N));
   assign w_err_sat  = (o_err_cnt == {ERR_W{1'b1}});
   assign o_state    = r_state;

   // Step-tracking FSM, statistics counters and registered event outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_UNSYNC;
         r_prev        <= {WIDTH{1'b0}};
         r_good        <= {GOOD_W{1'b0}};
         o_wrap_pulse  <= 1'b0;
         o_match_pulse <= 1'b0;
         o_seq_err     <= 1'b0;
         o_err_sticky  <= 1'b0;
         o_locked      <= 1'b0;
         o_wrap_cnt    <= {WRAP_W{1'b0}};
         o_err_cnt     <= {ERR_W{1'b0}};
      end else if (i_clear) begin
         r_state       <= ST_UNSYNC;
         r_prev        <= {WIDTH{1'b0}};
         r_good        <= {GOOD_W{1'b0}};
         o_wrap_pulse  <= 1'b0;
         o_match_pulse <= 1'b0;
         o_seq_err     <= 1'b0;
         o_err_sticky  <= 1'b0;
         o_locked      <= 1'b0;
         o_wrap_cnt    <= {WRAP_W{1'b0}};
         o_err_cnt     <= {ERR_W{1'b0}};
      end else begin
         o_wrap_pulse  <= w_wrap_evt;
         o_seq_err     <= w_bad_evt;
         o_match_pulse <= i_en && (i_cnt == i_cmp_val);
         o_err_sticky  <= o_err_sticky | w_bad_evt;

         if (w_wrap_evt) begin
            o_wrap_cnt <= o_wrap_cnt + {{(WRAP_W-1){1'b0}}, 1'b1};
         end else begin
            o_wrap_cnt <= o_wrap_cnt;
         end

         if (w_bad_evt && !w_err_sat) begin
            o_err_cnt <= o_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
         end else begin
            o_err_cnt <= o_err_cnt;
         end

         if (i_en) begin
            r_prev <= i_cnt;
         end else begin
            r_prev <= r_prev;
         end

         case (r_state)
            ST_UNSYNC: begin
               if (i_en) begin
                  r_good   <= {GOOD_W{1'b0}};
                  r_state  <= ST_RESYNC;
                  o_locked <= 1'b0;
               end else begin
                  r_state  <= ST_UNSYNC;
               end
            end
            ST_RESYNC: begin
               if (i_en && w_inc) begin
                  r_good <= w_good_inc;
                  if (w_lock_hit) begin
                     r_state  <= ST_TRACK;
                     o_locked <= 1'b1;
                  end else begin
                     r_state  <= ST_RESYNC;
                  end
               end else if (w_bad_evt) begin
                  r_good  <= {GOOD_W{1'b0}};
                  r_state <= ST_RESYNC;
               end else begin
                  r_state <= ST_RESYNC;
               end
            end
            ST_TRACK: begin
               if (w_bad_evt) begin
                  r_good   <= {GOOD_W{1'b0}};
                  r_state  <= ST_RESYNC;
                  o_locked <= 1'b0;
               end else begin
                  r_state  <= ST_TRACK;
               end
            end
            default: begin
               // Unreachable code: recover to a fresh capture on the next edge.
               r_good   <= {GOOD_W{1'b0}};
               r_state  <= ST_UNSYNC;
               o_locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: lock-in, wrap, hold, errors, saturation, reset and clear.
module tb_count_seq_monitor;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       clear;
   logic [3:0] cnt;
   logic [3:0] cmp_val;
   logic       wrap_pulse;
   logic       match_pulse;
   logic       seq_err;
   logic       err_sticky;
   logic       locked;
   logic [7:0] wrap_cnt;
   logic [3:0] err_cnt;
   logic [1:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   count_seq_monitor #(.WIDTH(4), .WRAP_W(8), .ERR_W(4), .LOCK_N(2)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_en          (en),
      .i_clear       (clear),
      .i_cnt         (cnt),
      .i_cmp_val     (cmp_val),
      .o_wrap_pulse  (wrap_pulse),
      .o_match_pulse (match_pulse),
      .o_seq_err     (seq_err),
      .o_err_sticky  (err_sticky),
      .o_locked      (locked),
      .o_wrap_cnt    (wrap_cnt),
      .o_err_cnt     (err_cnt),
      .o_state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic sample(input logic [3:0] c, input logic e);
      cnt = c;
      en  = e;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clear = 1'b0; cnt = 4'd0; cmp_val = 4'd15;
      #12;
      check("rst_state", 32'(state), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
      rst_n = 1'b1;

      // Lock-in: 0,1,2,3
      sample(4'd0, 1'b1);
      check("t1_state0", 32'(state), 32'd1);
      check("t1_locked0", 32'(locked), 32'd0);
      sample(4'd1, 1'b1);
      check("t1_state1", 32'(state), 32'd1);
      check("t1_seq1", 32'(seq_err), 32'd0);
      sample(4'd2, 1'b1);
      check("t1_state2", 32'(state), 32'd2);
      check("t1_locked2", 32'(locked), 32'd1);
      sample(4'd3, 1'b1);
      check("t1_state3", 32'(state), 32'd2);
      check("t1_seq3", 32'(seq_err), 32'd0);
      check("t1_match3", 32'(match_pulse), 32'd0);

      // Wrap with match on 0
      cmp_val = 4'd0;
      for (int v = 4; v <= 15; v++) begin
         sample(4'(v), 1'b1);
         check("t2_nowrap", 32'(wrap_pulse), 32'd0);
      end
      sample(4'd0, 1'b1);
      check("t2_wrap", 32'(wrap_pulse), 32'd1);
      check("t2_match", 32'(match_pulse), 32'd1);
      check("t2_wrap_cnt", 32'(wrap_cnt), 32'd1);
      check("t2_seq", 32'(seq_err), 32'd0);
      sample(4'd1, 1'b1);
      check("t2_wrap_drop", 32'(wrap_pulse), 32'd0);
      check("t2_match_drop", 32'(match_pulse), 32'd0);
      check("t2_wrap_cnt1", 32'(wrap_cnt), 32'd1);

      // Hold then bad step then re-lock
      for (int v = 2; v <= 5; v++) sample(4'(v), 1'b1);
      sample(4'd5, 1'b1);
      check("t3_hold_seq", 32'(seq_err), 32'd0);
      check("t3_hold_locked", 32'(locked), 32'd1);
      sample(4'd6, 1'b1);
      check("t3_inc_seq", 32'(seq_err), 32'd0);
      sample(4'd9, 1'b1);
      check("t3_bad_seq", 32'(seq_err), 32'd1);
      check("t3_bad_err_cnt", 32'(err_cnt), 32'd1);
      check("t3_bad_sticky", 32'(err_sticky), 32'd1);
      check("t3_bad_state", 32'(state), 32'd1);
      check("t3_bad_locked", 32'(locked), 32'd0);
      sample(4'd10, 1'b1);
      check("t3_relock_state1", 32'(state), 32'd1);
      check("t3_seq_drop", 32'(seq_err), 32'd0);
      sample(4'd11, 1'b1);
      check("t3_relock_state2", 32'(state), 32'd2);
      check("t3_relock_locked", 32'(locked), 32'd1);

      // Saturating error count
      for (int i = 0; i < 20; i++) begin
         sample(((i % 2) == 0) ? 4'd0 : 4'd8, 1'b1);
         check("t4_seq", 32'(seq_err), 32'd1);
         check("t4_err_cnt", 32'(err_cnt), (i + 2 > 15) ? 32'd15 : 32'(i + 2));
      end
      sample(4'd3, 1'b0);
      check("t4_en0_seq", 32'(seq_err), 32'd0);
      check("t4_en0_err_cnt", 32'(err_cnt), 32'd15);
      check("t4_en0_state", 32'(state), 32'd1);

      // Async reset mid-operation
      sample(4'd9, 1'b1);
      sample(4'd10, 1'b1);
      check("t5_pre_locked", 32'(locked), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_locked", 32'(locked), 32'd0);
      check("t5_async_state", 32'(state), 32'd0);
      check("t5_async_err_cnt", 32'(err_cnt), 32'd0);
      check("t5_async_sticky", 32'(err_sticky), 32'd0);
      check("t5_async_wrap_cnt", 32'(wrap_cnt), 32'd0);
      #3;
      rst_n = 1'b1;
      sample(4'd7, 1'b1);
      check("t5_capture_state", 32'(state), 32'd1);
      check("t5_capture_seq", 32'(seq_err), 32'd0);
      sample(4'd8, 1'b1);
      check("t5_inc_seq", 32'(seq_err), 32'd0);
      sample(4'd9, 1'b1);
      check("t5_relock", 32'(state), 32'd2);

      // Clear beats a bad sample
      sample(4'd2, 1'b1);
      check("t6_pre_err_cnt", 32'(err_cnt), 32'd1);
      clear = 1'b1;
      sample(4'd5, 1'b1);
      clear = 1'b0;
      check("t6_clr_err_cnt", 32'(err_cnt), 32'd0);
      check("t6_clr_state", 32'(state), 32'd0);
      check("t6_clr_seq", 32'(seq_err), 32'd0);
      check("t6_clr_sticky", 32'(err_sticky), 32'd0);
      sample(4'd6, 1'b1);
      check("t6_post_state", 32'(state), 32'd1);
      check("t6_post_seq", 32'(seq_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
